// File: rtl/ap_ctrl_driver.sv
// ap_ctrl_driver
//   Initiator side of the HLS block-level ap_ctrl handshake. Accepts a batch command of N
//   transactions, issues ap_start handshakes to a kernel while bounding the number of
//   started-but-not-finished transactions, counts completions, and reports batch timing.
//
// Build option:
//   AP_CTRL_CHAIN_EN  defined   -> ap_ctrl_chain: ap_continue = ap_done & cons_ready
//                     undefined -> ap_ctrl_hs:    ap_continue = 1, cons_ready ignored
//
// Ports:
//   ap_clk, ap_rst              clock, synchronous active-high reset
//   cmd_valid/cmd_ready/cmd_count  batch request handshake (count sampled on accept)
//   abort                       level; stop issuing, drain outstanding work
//   ap_start/ap_ready           start handshake to/from kernel
//   ap_done/ap_continue         completion handshake from/to kernel
//   cons_ready                  downstream ready (chain mode only)
//   busy, batch_done            status: running/draining, one-cycle completion pulse
//   issued_cnt, done_cnt        start handshakes / completions in the current batch
//   batch_cycles                RUN+DRAIN cycles of the batch, saturating
//   err_spurious                one-cycle pulse on a completion with nothing outstanding
module ap_ctrl_driver #(
  parameter int unsigned CNT_W           = 16,
  parameter int unsigned CYC_W           = 32,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic             ap_clk,
  input  logic             ap_rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic             abort,
  output logic             ap_start,
  input  logic             ap_ready,
  input  logic             ap_done,
  output logic             ap_continue,
  input  logic             cons_ready,
  output logic             busy,
  output logic             batch_done,
  output logic [CNT_W-1:0] issued_cnt,
  output logic [CNT_W-1:0] done_cnt,
  output logic [CYC_W-1:0] batch_cycles,
  output logic             err_spurious
);

  localparam int unsigned OutW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [OutW-1:0] MaxOut = OutW'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e           state_q, state_d;
  logic             ap_start_q, ap_start_d;
  logic             batch_done_q, batch_done_d;
  logic             err_q;
  logic [OutW-1:0]  out_q, out_d;
  logic [CNT_W-1:0] n_q, n_d;
  logic [CNT_W-1:0] issued_q, issued_d;
  logic [CNT_W-1:0] done_q, done_d;
  logic [CYC_W-1:0] cycles_q, cycles_d, cycles_inc;

  logic start_hs, comp_ev, spurious, comp_ok;

`ifdef AP_CTRL_CHAIN_EN
  assign ap_continue = ap_done & cons_ready;
`else
  logic unused_cons_ready;
  assign unused_cons_ready = cons_ready;
  assign ap_continue       = 1'b1;
`endif

  assign start_hs = ap_start_q & ap_ready;
  assign comp_ev  = ap_done & ap_continue;
  // A completion with nothing outstanding is reported, never counted.
  assign spurious = comp_ev & (out_q == '0);
  assign comp_ok  = comp_ev & ~spurious;

  assign cycles_inc = (cycles_q == '1) ? cycles_q : cycles_q + CYC_W'(1);

  // Outstanding tracker: a simultaneous start and completion cancel out.
  always_comb begin
    out_d = out_q;
    if (start_hs && !comp_ok) begin
      out_d = out_q + OutW'(1);
    end else if (!start_hs && comp_ok) begin
      out_d = out_q - OutW'(1);
    end
  end

  always_comb begin
    state_d      = state_q;
    ap_start_d   = 1'b0;
    batch_done_d = 1'b0;
    n_d          = n_q;
    issued_d     = issued_q + CNT_W'(start_hs);
    done_d       = done_q + CNT_W'(comp_ok);
    cycles_d     = cycles_q;
    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          n_d      = cmd_count;
          issued_d = '0;
          done_d   = '0;
          if (cmd_count == '0) begin
            state_d  = StDone;
            cycles_d = '0;
          end else begin
            state_d    = StRun;
            cycles_d   = CYC_W'(1);
            ap_start_d = 1'b1;
          end
        end
      end
      StRun: begin
        cycles_d = cycles_inc;
        if (ap_start_q && !ap_ready) begin
          // A request already on the wire is held until the kernel takes it.
          ap_start_d = 1'b1;
        end else if ((issued_d >= n_q) || abort) begin
          state_d = StDrain;
        end else begin
          ap_start_d = (out_d < MaxOut);
        end
      end
      StDrain: begin
        if (out_q == '0) begin
          state_d = StDone;
        end else begin
          cycles_d = cycles_inc;
        end
      end
      StDone: begin
        state_d      = StIdle;
        batch_done_d = 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q      <= StIdle;
      ap_start_q   <= 1'b0;
      batch_done_q <= 1'b0;
      err_q        <= 1'b0;
      out_q        <= '0;
      n_q          <= '0;
      issued_q     <= '0;
      done_q       <= '0;
      cycles_q     <= '0;
    end else begin
      state_q      <= state_d;
      ap_start_q   <= ap_start_d;
      batch_done_q <= batch_done_d;
      err_q        <= spurious;
      out_q        <= out_d;
      n_q          <= n_d;
      issued_q     <= issued_d;
      done_q       <= done_d;
      cycles_q     <= cycles_d;
    end
  end

  assign cmd_ready    = (state_q == StIdle);
  assign busy         = (state_q == StRun) || (state_q == StDrain);
  assign ap_start     = ap_start_q;
  assign batch_done   = batch_done_q;
  assign issued_cnt   = issued_q;
  assign done_cnt     = done_q;
  assign batch_cycles = cycles_q;
  assign err_spurious = err_q;

endmodule

// File: tb/tb_ap_ctrl_driver.sv
// Bench for ap_ctrl_driver: a kernel model plus a timestamp-based reference model of the
// batch (counts of starts/completions, close and last-completion cycles), directed table
// vectors, hand sequences for abort/reset/chain stalls, and randomized batches.
module tb_ap_ctrl_driver;

  localparam int MaxOut = 2;
`ifdef AP_CTRL_CHAIN_EN
  localparam bit Chain = 1'b1;
`else
  localparam bit Chain = 1'b0;
`endif

  logic        ap_clk = 1'b0;
  logic        ap_rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic [15:0] cmd_count = '0;
  logic        abort = 1'b0;
  logic        ap_ready = 1'b0;
  logic        ap_done = 1'b0;
  logic        cons_ready = 1'b1;
  logic        cmd_ready, ap_start, ap_continue, busy, batch_done, err_spurious;
  logic [15:0] issued_cnt, done_cnt;
  logic [31:0] batch_cycles;

  ap_ctrl_driver #(.CNT_W(16), .CYC_W(32), .MAX_OUTSTANDING(MaxOut)) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_count(cmd_count), .abort(abort), .ap_start(ap_start), .ap_ready(ap_ready),
    .ap_done(ap_done), .ap_continue(ap_continue), .cons_ready(cons_ready), .busy(busy),
    .batch_done(batch_done), .issued_cnt(issued_cnt), .done_cnt(done_cnt),
    .batch_cycles(batch_cycles), .err_spurious(err_spurious)
  );

  always #5 ap_clk = ~ap_clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  // Reference model of the current batch.
  bit m_in_batch, m_closed, m_err;
  int m_n, m_c0, m_iss, m_cmp, m_tlast;

  // Kernel model.
  int due_q[$];
  int last_due = -1;
  int lat_lo = 1, lat_hi = 1, ready_pct = 100;
  bit cons_rand = 0;
  int cons_low_from = -1, cons_low_to = -1;

  // Observations.
  int bd_seen_c, err_seen, stall_seen;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_in_batch = 0; m_closed = 0; m_err = 0;
    m_n = 0; m_c0 = 0; m_iss = 0; m_cmp = 0; m_tlast = -1;
  endtask

  // One clock cycle: drive inputs, check outputs against the model, advance the model.
  task automatic step(input bit cv, input int cnt, input bit ab, input bit rs, input bit spur);
    bit hs, comp, acc, exp_cr, exp_busy, exp_bd, exp_start;
    int out, exp_cyc, due, ev_c;
    ap_done  = spur || (due_q.size() > 0 && due_q[0] <= cyc);
    ap_ready = ($urandom_range(0, 99) < ready_pct);
    if (cyc >= cons_low_from && cyc <= cons_low_to) cons_ready = 1'b0;
    else cons_ready = cons_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
    cmd_valid = cv;
    cmd_count = 16'(cnt);
    abort     = ab;
    ap_rst    = rs;
    #1;
    out       = m_iss - m_cmp;
    exp_cr    = !(m_in_batch && (m_tlast < 0 || cyc <= m_tlast + 2));
    exp_busy  = m_in_batch && (m_tlast < 0 || cyc <= m_tlast + 1);
    exp_bd    = m_in_batch && m_tlast >= 0 && cyc == m_tlast + 3;
    exp_start = m_in_batch && !m_closed && m_iss < m_n && out < MaxOut;
    exp_cyc   = !m_in_batch ? 0 : (m_tlast < 0 ? cyc - m_c0 : m_tlast + 1 - m_c0);
    chk("ap_start", ap_start, exp_start);
    chk("cmd_ready", cmd_ready, exp_cr);
    chk("busy", busy, exp_busy);
    chk("batch_done", batch_done, exp_bd);
    chk("issued_cnt", issued_cnt, m_iss);
    chk("done_cnt", done_cnt, m_cmp);
    chk("batch_cycles", batch_cycles, exp_cyc);
    chk("err_spurious", err_spurious, m_err);
    chk("ap_continue", ap_continue, Chain ? (ap_done & cons_ready) : 1'b1);
    chk("outstanding_bound", (out <= MaxOut), 1);
    if (batch_done) bd_seen_c = cyc;
    if (err_spurious) err_seen++;
    if (ap_done && !ap_continue) stall_seen++;
    hs   = ap_start && ap_ready;
    comp = ap_done && (Chain ? cons_ready : 1'b1);
    acc  = cv && exp_cr;
    if (comp && due_q.size() > 0 && due_q[0] <= cyc) void'(due_q.pop_front());
    if (hs) begin
      due = cyc + int'($urandom_range(lat_lo, lat_hi));
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      due_q.push_back(due);
    end
    ev_c = cyc;
    @(posedge ap_clk);
    #1;
    cyc++;
    if (rs) begin
      model_reset();
    end else begin
      m_err = comp && (m_iss == m_cmp);
      if (comp && !m_err) m_cmp++;
      if (hs) m_iss++;
      if (acc) begin
        m_in_batch = 1; m_n = cnt; m_c0 = ev_c; m_iss = 0; m_cmp = 0;
        m_closed = 0; m_tlast = -1;
        if (cnt == 0) begin
          m_closed = 1;
          m_tlast  = ev_c - 1;
        end
      end else if (m_in_batch && !m_closed && (m_iss >= m_n || ab)) begin
        m_closed = 1;
      end
      if (m_in_batch && m_closed && m_tlast < 0 && m_cmp == m_iss) m_tlast = ev_c;
    end
  endtask

  // Issue one batch from IDLE and run until it finishes (or settles after a reset).
  task automatic run_batch(input int n, input int ab_off, input int rs_off, output int bd_off);
    int start_c;
    bit finished;
    bd_seen_c = -1;
    start_c   = cyc;
    finished  = 0;
    step(1, n, 0, 0, 0);
    for (int k = 1; k <= 400; k++) begin
      if (rs_off < 0 && m_tlast >= 0 && cyc > m_tlast + 3) begin
        finished = 1;
        break;
      end
      if (rs_off >= 0 && !m_in_batch && k > rs_off + 15) begin
        finished = 1;
        break;
      end
      step(0, 0, (ab_off >= 0 && k >= ab_off), (rs_off >= 0 && k == rs_off), 0);
    end
    chk("batch_terminates", finished, 1);
    bd_off = (bd_seen_c >= 0) ? bd_seen_c - start_c : -1;
  endtask

  typedef struct {
    int n; int lat; int ab_off;
    int e_iss; int e_done; int e_cyc; int e_bd;
  } vec_t;

  vec_t tbl[5];

  initial begin
    int bd_off;
    tbl[0] = '{n: 4, lat: 10, ab_off: -1, e_iss: 4, e_done: 4, e_cyc: 24, e_bd: 26};
    tbl[1] = '{n: 1, lat: 1,  ab_off: -1, e_iss: 1, e_done: 1, e_cyc: 3,  e_bd: 5};
    tbl[2] = '{n: 3, lat: 2,  ab_off: -1, e_iss: 3, e_done: 3, e_cyc: 7,  e_bd: 9};
    tbl[3] = '{n: 0, lat: 5,  ab_off: -1, e_iss: 0, e_done: 0, e_cyc: 0,  e_bd: 2};
    tbl[4] = '{n: 8, lat: 10, ab_off: 3,  e_iss: 2, e_done: 2, e_cyc: 13, e_bd: 15};

    model_reset();
    repeat (2) @(posedge ap_clk);
    #1;
    ap_rst = 1'b0;

    // Reset state, then a completion in IDLE: one err pulse, counters untouched.
    step(0, 0, 0, 0, 0);
    err_seen = 0;
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("idle_spurious_pulses", err_seen, 1);

    // Directed table: kernel ready on start, fixed latency.
    ready_pct = 100;
    for (int i = 0; i < 5; i++) begin
      lat_lo = tbl[i].lat;
      lat_hi = tbl[i].lat;
      run_batch(tbl[i].n, tbl[i].ab_off, -1, bd_off);
      chk("tbl_issued", issued_cnt, tbl[i].e_iss);
      chk("tbl_done", done_cnt, tbl[i].e_done);
      chk("tbl_cycles", batch_cycles, tbl[i].e_cyc);
      chk("tbl_bd_offset", bd_off, tbl[i].e_bd);
      chk("tbl_busy_after", busy, 0);
      step(0, 0, 0, 0, 0);
    end

    // Reset mid-RUN with two outstanding; the two late dones are spurious.
    lat_lo = 10;
    lat_hi = 10;
    err_seen = 0;
    run_batch(4, -1, 4, bd_off);
    chk("rst_late_spurious", err_seen, 2);
    chk("rst_issued", issued_cnt, 0);
    chk("rst_no_batch_done", bd_off, -1);

`ifdef AP_CTRL_CHAIN_EN
    // Done held while downstream stalls for 5 cycles: counted once, on release.
    lat_lo = 2;
    lat_hi = 2;
    stall_seen = 0;
    cons_low_from = cyc + 3;
    cons_low_to   = cyc + 7;
    run_batch(1, -1, -1, bd_off);
    cons_low_from = -1;
    cons_low_to   = -1;
    chk("chain_stall_cycles", stall_seen, 5);
    chk("chain_done", done_cnt, 1);
`endif

    // Randomized batches with random ready, latency and idle spurious dones.
    ready_pct = 60;
    lat_lo    = 1;
    lat_hi    = 8;
    cons_rand = 1;
    for (int b = 0; b < 25; b++) begin
      int n;
      n = int'($urandom_range(1, 6));
      run_batch(n, -1, -1, bd_off);
      chk("rand_done_total", done_cnt, n);
      for (int g = 0; g < int'($urandom_range(0, 3)); g++) begin
        step(0, 0, 0, 0, ($urandom_range(0, 3) == 0) && (due_q.size() == 0));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
